servo_history_lifo: RTL



---
 rtl/servo_history_lifo_if.sv | 34 +++
 rtl/servo_history_lifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/servo_history_lifo_if.sv
// servo_history_lifo_if
// Bundles the sample strobe, mode select, live set-points and the replay /
// status outputs of the servo history LIFO.
//   master : drives sample_tick, backtrack_active, x_val, y_val;
//            observes x_val_out, y_val_out, out_valid, count, empty, full, done
//   slave  : the LIFO itself (mirror image of master)
interface servo_history_lifo_if #(
  parameter int VAL_W = 11,
  parameter int DEPTH = 25
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             sample_tick;
  logic             backtrack_active;
  logic [VAL_W-1:0] x_val;
  logic [VAL_W-1:0] y_val;
  logic [VAL_W-1:0] x_val_out;
  logic [VAL_W-1:0] y_val_out;
  logic             out_valid;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             done;

  modport master (
    output sample_tick, backtrack_active, x_val, y_val,
    input  x_val_out, y_val_out, out_valid, count, empty, full, done
  );

  modport slave (
    input  sample_tick, backtrack_active, x_val, y_val,
    output x_val_out, y_val_out, out_valid, count, empty, full, done
  );
endinterface

// File: rtl/servo_history_lifo.sv
// servo_history_lifo
// Circular LIFO of DEPTH (x, y) servo set-point pairs. While backtrack_active
// is low every sample_tick pushes the live pair (oldest entry overwritten once
// full). While it is high every sample_tick pops the newest pair onto the
// registered outputs until the history runs out, at which point done rises.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : servo_history_lifo_if.slave (tick, mode, live values, replay
//           outputs, count/empty/full/done status)
module servo_history_lifo #(
  parameter int VAL_W  = 11,
  parameter int DEPTH  = 25,
  parameter int X_IDLE = 1500,
  parameter int Y_IDLE = 1200
) (
  input logic                 clk,
  input logic                 rst_n,
  servo_history_lifo_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [VAL_W-1:0] X_IDLE_V = VAL_W'(X_IDLE);
  localparam logic [VAL_W-1:0] Y_IDLE_V = VAL_W'(Y_IDLE);

  typedef enum logic [1:0] {
    ST_RECORD   = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t             state;
  logic [2*VAL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [VAL_W-1:0]   x_out;
  logic [VAL_W-1:0]   y_out;
  logic               valid_out;
  logic               done_out;
  logic [PTR_W-1:0]   top_ptr;

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_ZERO) ? PTR_LAST : p - PTR_ONE;
  endfunction

  // Top of stack sits one slot below the next write slot.
  always_comb begin
    top_ptr = ptr_dec(wr_ptr);
  end

  // History store; no reset needed because count gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.backtrack_active && bus.sample_tick) begin
      mem[wr_ptr] <= {bus.x_val, bus.y_val};
    end
  end

  // Mode FSM, pointer/count bookkeeping and registered replay outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RECORD;
      wr_ptr    <= PTR_ZERO;
      cnt       <= CNT_ZERO;
      x_out     <= X_IDLE_V;
      y_out     <= Y_IDLE_V;
      valid_out <= 1'b0;
      done_out  <= 1'b0;
    end else if (!bus.backtrack_active) begin
      // Mode is sampled this cycle, so a coincident tick is a push.
      state     <= ST_RECORD;
      x_out     <= X_IDLE_V;
      y_out     <= Y_IDLE_V;
      valid_out <= 1'b0;
      done_out  <= 1'b0;
      if (bus.sample_tick) begin
        wr_ptr <= ptr_inc(wr_ptr);
        if (cnt != CNT_FULL) begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end else begin
      case (state)
        // RECORD shares the pop path: the tick that arrives with the
        // rising mode edge is already a pop.
        ST_RECORD, ST_PLAYBACK: begin
          state <= ST_PLAYBACK;
          if (bus.sample_tick) begin
            if (cnt != CNT_ZERO) begin
              {x_out, y_out} <= mem[top_ptr];
              valid_out      <= 1'b1;
              wr_ptr         <= top_ptr;
              cnt            <= cnt - CNT_ONE;
            end else begin
              // History exhausted: outputs and out_valid hold.
              state    <= ST_DONE;
              done_out <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state     <= ST_RECORD;
          x_out     <= X_IDLE_V;
          y_out     <= Y_IDLE_V;
          valid_out <= 1'b0;
          done_out  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_val_out = x_out;
  assign bus.y_val_out = y_out;
  assign bus.out_valid = valid_out;
  assign bus.done      = done_out;
  assign bus.count     = cnt;
  assign bus.empty     = (cnt == CNT_ZERO);
  assign bus.full      = (cnt == CNT_FULL);

endmodule
